// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared data memory port.
// Round-robin between core LSU (m0) and loader/debug (m1), with bounded m1 lock.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m0_bmask,
    input  logic [3:0]        m1_bmask,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_bmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t        state, state_d;
    logic          rr_fav1, rr_fav1_d;
    logic [LW-1:0] lock_cnt, lock_cnt_d;
    logic          rd_vld, rd_vld_d;
    logic          rd_own, rd_own_d;
    logic          g0, g1;
    logic          lock_win, pick1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_fav1  <= 1'b0;
            lock_cnt <= '0;
            rd_vld   <= 1'b0;
            rd_own   <= 1'b0;
        end else begin
            state    <= state_d;
            rr_fav1  <= rr_fav1_d;
            lock_cnt <= lock_cnt_d;
            rd_vld   <= rd_vld_d;
            rd_own   <= rd_own_d;
        end
    end

    // m1 keeps ownership only while the lock run is below its bound
    assign lock_win = (state == OWN1) && m1_lock && m1_req
                      && (lock_cnt < LW'(MAX_LOCK));
    assign pick1    = lock_win | rr_fav1;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        unique case (1'b1)
            (m0_req & ~m1_req):        g0 = 1'b1;
            (m1_req & ~m0_req):        g1 = 1'b1;
            (m0_req & m1_req & pick1): g1 = 1'b1;
            (m0_req & m1_req & ~pick1): g0 = 1'b1;
            default: ;
        endcase
    end

    assign m0_gnt = g0 & ~rst;
    assign m1_gnt = g1 & ~rst;

    always_comb begin
        state_d    = IDLE;
        rr_fav1_d  = rr_fav1;
        lock_cnt_d = '0;
        rd_vld_d   = 1'b0;
        rd_own_d   = 1'b0;
        if (m0_gnt) begin
            state_d   = OWN0;
            rr_fav1_d = 1'b1;
            rd_vld_d  = ~m0_we;
        end else if (m1_gnt) begin
            state_d   = OWN1;
            rr_fav1_d = 1'b0;
            rd_vld_d  = ~m1_we;
            rd_own_d  = 1'b1;
            if (m1_lock) begin
                lock_cnt_d = (lock_cnt == LW'(MAX_LOCK)) ? lock_cnt
                                                         : lock_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_bmask = '0;
        if (m0_gnt) begin
            mem_req   = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_bmask = m0_bmask;
        end else if (m1_gnt) begin
            mem_req   = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_bmask = m1_bmask;
        end
    end

    assign m0_rvalid = rd_vld & ~rd_own & ~rst;
    assign m1_rvalid = rd_vld & rd_own & ~rst;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
